// File: rtl/serial_adder.sv
// Bit-serial adder: latches A, B and Cin, then feeds one LSB-first bit pair per clock
// through the single-bit full adder fa, collecting Sum bits and recirculating the carry.

module fa (
   input  logic A,
   input  logic B,
   input  logic Cin,
   output logic Sum,
   output logic Cout
);
   assign Sum  = A ^ B ^ Cin;
   assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
   logic [CW-1:0]    count_q, count_d;
   logic             carry_q, carry_d, cout_q, cout_d;
   logic             fa_sum, fa_cout;

   // Insert a bit at the MSB end; written via a wider temporary so WIDTH=1 stays legal.
   function automatic logic [WIDTH-1:0] shift_in(input logic b, input logic [WIDTH-1:0] v);
      logic [WIDTH:0] t;
      t = {b, v};
      return t[WIDTH:1];
   endfunction

   fa u_fa (
      .A   (a_q[0]),
      .B   (b_q[0]),
      .Cin (carry_q),
      .Sum (fa_sum),
      .Cout(fa_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         count_q <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         count_q <= count_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      sum_d   = sum_q;
      count_d = count_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      unique case (state_q)
         IDLE, DONE: begin
            // DONE accepts a new request exactly like IDLE, giving back-to-back throughput.
            if (start) begin
               a_d     = A;
               b_d     = B;
               carry_d = Cin;
               res_d   = '0;
               count_d = '0;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            res_d   = shift_in(fa_sum, res_q);
            carry_d = fa_cout;
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            count_d = count_q + CW'(1);
            if (count_q == LAST) begin
               sum_d   = shift_in(fa_sum, res_q);
               cout_d  = fa_cout;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);
   assign Sum  = sum_q;
   assign Cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit and a 1-bit instance checked every cycle against an
// arithmetic model of the request/latency/result behaviour, plus literal spot checks.

module tb_serial_adder;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start8 = 1'b0, cin8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, cout8;
   logic [7:0] sum8;
   logic       start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
   logic       busy1, done1, cout1;
   logic       sum1;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .Cin(cin8),
      .busy(busy8), .done(done8), .Sum(sum8), .Cout(cout8)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .Cin(cin1),
      .busy(busy1), .done(done1), .Sum(sum1), .Cout(cout1)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: k counts cycles since acceptance (0 idle, 1..W busy, W+1 done).
   int       k8 = 0, k1 = 0;
   logic [8:0] pend8 = '0, res8 = '0;
   logic [1:0] pend1 = '0, res1 = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k8 <= 0; res8 <= '0; pend8 <= '0;
         k1 <= 0; res1 <= '0; pend1 <= '0;
      end else begin
         if (k8 == 0 || k8 == 9) begin
            if (start8) begin k8 <= 1; pend8 <= 9'(a8) + 9'(b8) + 9'(cin8); end
            else k8 <= 0;
         end else if (k8 == 8) begin
            k8 <= 9; res8 <= pend8;
         end else k8 <= k8 + 1;
         if (k1 == 0 || k1 == 2) begin
            if (start1) begin k1 <= 1; pend1 <= 2'(a1) + 2'(b1) + 2'(cin1); end
            else k1 <= 0;
         end else begin
            k1 <= 2; res1 <= pend1;
         end
      end
   end

   always @(negedge clk) begin
      check("busy8", 32'(busy8), 32'(k8 >= 1 && k8 <= 8));
      check("done8", 32'(done8), 32'(k8 == 9));
      check("sum8",  32'(sum8),  32'(res8[7:0]));
      check("cout8", 32'(cout8), 32'(res8[8]));
      check("busy1", 32'(busy1), 32'(k1 == 1));
      check("done1", 32'(done1), 32'(k1 == 2));
      check("res1",  32'({cout1, sum1}), 32'(res1));
      if (busy8 && done8) check("busy8_and_done8", 32'(1), 32'(0));
   end

   // Waits for done8 at sampling points; returns the number of cycles taken.
   task automatic wait_done8(input int budget, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk); #1;
         cyc++;
      end while (!done8 && cyc < budget);
      if (!done8) check("done8_timeout", 32'(0), 32'(1));
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, output int cyc);
      @(negedge clk); #1;
      a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
      @(negedge clk); #1;
      start8 = 1'b0;
      wait_done8(20, cyc);
      cyc++;
   endtask

   int cyc;

   initial begin
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      check("idle_sum", 32'(sum8), 32'h00);
      check("idle_busy", 32'(busy8), 32'(0));

      op8(8'h35, 8'h4A, 1'b0, cyc);
      check("basic_sum", 32'(sum8), 32'h7F);
      check("basic_cout", 32'(cout8), 32'(0));
      check("basic_latency", 32'(cyc), 32'(9));
      repeat (3) @(negedge clk);
      #1 check("basic_hold", 32'(sum8), 32'h7F);

      op8(8'hFF, 8'h00, 1'b1, cyc);
      check("chain1", 32'({cout8, sum8}), 32'h100);
      op8(8'hFF, 8'hFF, 1'b1, cyc);
      check("chain2", 32'({cout8, sum8}), 32'h1FF);

      // A start pulse during SHIFT must be ignored.
      @(negedge clk); #1;
      a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk); #1 start8 = 1'b0;
      repeat (2) @(negedge clk);
      #1 a8 = 8'hAA; start8 = 1'b1;
      @(negedge clk); #1 start8 = 1'b0;
      wait_done8(20, cyc);
      check("ignored_sum", 32'(sum8), 32'h02);
      repeat (12) @(negedge clk);
      #1 check("ignored_no_second", 32'(sum8), 32'h02);

      // Back-to-back with start held high.
      @(negedge clk); #1;
      a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk); #1 a8 = 8'h80; b8 = 8'h80;
      wait_done8(20, cyc);
      check("b2b_first", 32'({cout8, sum8}), 32'h030);
      check("b2b_first_lat", 32'(cyc), 32'(8));
      @(negedge clk); #1 start8 = 1'b0;
      wait_done8(20, cyc);
      check("b2b_second", 32'({cout8, sum8}), 32'h100);
      check("b2b_second_lat", 32'(cyc), 32'(8));

      // Reset in the middle of SHIFT aborts the operation.
      @(negedge clk); #1;
      a8 = 8'h33; b8 = 8'h44; start8 = 1'b1;
      @(negedge clk); #1 start8 = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy8), 32'(0));
      check("abort_done", 32'(done8), 32'(0));
      check("abort_sum", 32'(sum8), 32'(0));
      @(negedge clk); #1;
      rst_n = 1'b1; a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk); #1 start8 = 1'b0;
      wait_done8(20, cyc);
      check("after_abort_sum", 32'(sum8), 32'h10);
      check("after_abort_lat", 32'(cyc), 32'(8));

      // Randomized traffic, inputs changing every cycle.
      for (int i = 0; i < 600; i++) begin
         @(negedge clk); #1;
         a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
         start8 = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk); #1 start8 = 1'b0;
      repeat (12) @(negedge clk);

      // WIDTH=1: all operand combinations back-to-back, two cycles each.
      @(negedge clk); #1;
      for (int i = 0; i < 8; i++) begin
         {a1, b1, cin1} = 3'(i);
         start1 = 1'b1;
         repeat (2) @(negedge clk);
         #1;
         check("w1_done", 32'(done1), 32'(1));
         check("w1_truth", 32'({cout1, sum1}), 32'($countones(i)));
      end
      start1 = 1'b0;
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got 0 expected 1");
      $fatal(1, "timeout");
   end

endmodule
